conv_layer_sequencer: RTL

- Drives one conv_top instance through a full layer: one bias load, then per output group (OG) a weight load, go, pixel stream, done wait and flush/reset.
- Replaces the task-based sequencing used in simulation with synthesizable control.
- Consumes three valid/ready source streams (bias, weight, pixel) plus a quant-parameter table written by the host.
- Emits conv_top's write, config, pixel and reset inputs.

---
 rtl/conv_layer_sequencer.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
//   Sequences one conv_top instance through a complete layer. It loads the
//   biases once. Then, for each output group (OG), it loads the weights,
//   pulses go, streams pixels, waits for done, flushes the pipeline with
//   zero pixels and soft-resets conv_top. Per-OG quantisation parameters come
//   from a small table that the host writes.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   start, cfg_*                  layer start pulse and layer geometry
//   qt_wr_*                       quant table write port (m multiplier, n shift)
//   bias_s_*, wt_s_*, px_s_*      source streams (valid/ready)
//   bias_wr_*, wt_wr_*            memory write controls to conv_top
//   pixel_out*                    pixel stream to conv_top
//   conv_go, conv_done            conv_top start / completion
//   conv_soft_rst                 ORed into conv_top reset by the parent
//   conv_output_group, conv_quant_m/n, conv_wt_base_addr   per-OG config
//   busy, layer_done, err_last    status
//
// Handshake: a beat transfers on a rising clk edge where valid && ready.
// Each ready output depends only on the FSM state and never on valid. The
// matching write enable and data are combinational copies of the source
// valid and data during the load and stream states.

module conv_layer_sequencer #(
    parameter int MAX_OG           = 64,
    parameter int WT_ADDR_WIDTH    = 12,
    parameter int FLUSH_RST_CYCLES = 5,
    parameter int FLUSH_GAP_CYCLES = 2,
    localparam int QT_AW = (MAX_OG > 1) ? $clog2(MAX_OG) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               cfg_co_groups,
    input  logic [9:0]               cfg_ci_groups,
    input  logic [15:0]              cfg_img_width,
    input  logic [15:0]              cfg_img_height,
    input  logic                     qt_wr_en,
    input  logic [QT_AW-1:0]         qt_wr_addr,
    input  logic [31:0]              qt_wr_m,
    input  logic [4:0]               qt_wr_n,
    input  logic [127:0]             bias_s_data,
    input  logic                     bias_s_valid,
    output logic                     bias_s_ready,
    input  logic [71:0]              wt_s_data,
    input  logic                     wt_s_valid,
    output logic                     wt_s_ready,
    input  logic [63:0]              px_s_data,
    input  logic                     px_s_valid,
    input  logic                     px_s_last,
    output logic                     px_s_ready,
    output logic                     bias_wr_en,
    output logic                     bias_wr_addr_rst,
    output logic [127:0]             bias_wr_data,
    output logic                     wt_wr_en,
    output logic                     wt_wr_addr_rst,
    output logic [71:0]              wt_wr_data,
    output logic [63:0]              pixel_out,
    output logic                     pixel_out_valid,
    output logic                     pixel_out_last,
    output logic                     conv_go,
    input  logic                     conv_done,
    output logic                     conv_soft_rst,
    output logic [7:0]               conv_output_group,
    output logic [31:0]              conv_quant_m,
    output logic [4:0]               conv_quant_n,
    output logic [WT_ADDR_WIDTH-1:0] conv_wt_base_addr,
    output logic                     busy,
    output logic                     layer_done,
    output logic                     err_last
);

    typedef enum logic [3:0] {
        IDLE, B_RST, B_LOAD, W_RST, W_LOAD, GO, STREAM,
        WAIT_DONE, FLUSH, F_RST, F_GAP, NEXT, DONE
    } state_t;

    state_t state, state_next;

    logic [7:0]  co_q;
    logic [9:0]  ci_q;
    logic [15:0] w_q, h_q;
    logic [31:0] cnt, cnt_next, cnt_inc;
    logic [7:0]  og, og_load;
    logic        done_seen;
    logic        accept, load_og, og_advance;

    logic [31:0] qt_m [MAX_OG];
    logic [4:0]  qt_n [MAX_OG];
    logic [QT_AW-1:0] qt_idx;

    logic [31:0] bias_total, wt_total, px_total, flush_total, wh;

    // All totals are 32-bit. Oversized geometries wrap instead of widening.
    assign bias_total  = {23'd0, co_q, 1'b0};
    assign wt_total    = {16'd0, ci_q, 6'd0};
    assign wh          = 32'(w_q) * 32'(h_q);
    assign px_total    = wh * 32'(ci_q);
    assign flush_total = ((32'(w_q) * 32'(ci_q)) << 1) + 32'd4;
    assign cnt_inc     = cnt + 32'd1;

    // The OG whose parameters are presented while it is processed. In NEXT
    // the counter has not advanced yet, so look one ahead.
    assign og_load = og_advance ? og + 8'd1 : og;
    assign qt_idx  = QT_AW'(og_load);

    assign conv_wt_base_addr = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        accept           = 1'b0;
        load_og          = 1'b0;
        og_advance       = 1'b0;
        bias_s_ready     = 1'b0;
        wt_s_ready       = 1'b0;
        px_s_ready       = 1'b0;
        bias_wr_en       = 1'b0;
        bias_wr_addr_rst = 1'b0;
        bias_wr_data     = '0;
        wt_wr_en         = 1'b0;
        wt_wr_addr_rst   = 1'b0;
        wt_wr_data       = '0;
        pixel_out        = '0;
        pixel_out_valid  = 1'b0;
        pixel_out_last   = 1'b0;
        conv_go          = 1'b0;
        conv_soft_rst    = 1'b0;
        layer_done       = 1'b0;
        busy             = (state != IDLE) && (state != DONE);

        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    cnt_next   = '0;
                    state_next = (cfg_co_groups == 8'd0) ? DONE : B_RST;
                end
            end
            B_RST: begin
                bias_wr_addr_rst = 1'b1;
                state_next       = B_LOAD;
            end
            B_LOAD: begin
                bias_s_ready = 1'b1;
                bias_wr_en   = bias_s_valid;
                bias_wr_data = bias_s_valid ? bias_s_data : '0;
                if (bias_s_valid) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc >= bias_total) begin
                        cnt_next   = '0;
                        load_og    = 1'b1;
                        state_next = W_RST;
                    end
                end
            end
            W_RST: begin
                wt_wr_addr_rst = 1'b1;
                state_next     = W_LOAD;
            end
            W_LOAD: begin
                wt_s_ready = 1'b1;
                wt_wr_en   = wt_s_valid;
                wt_wr_data = wt_s_valid ? wt_s_data : '0;
                if (wt_s_valid) cnt_next = cnt_inc;
                if (wt_total == 32'd0 || (wt_s_valid && cnt_inc >= wt_total)) begin
                    cnt_next   = '0;
                    state_next = GO;
                end
            end
            GO: begin
                conv_go    = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                px_s_ready      = 1'b1;
                pixel_out_valid = px_s_valid;
                pixel_out       = px_s_valid ? px_s_data : '0;
                pixel_out_last  = px_s_valid && (cnt_inc == px_total);
                if (px_s_valid) cnt_next = cnt_inc;
                // The internal beat count decides when the stream ends.
                // px_s_last is only checked against it.
                if (px_total == 32'd0 || (px_s_valid && cnt_inc >= px_total)) begin
                    cnt_next   = '0;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_seen || conv_done) state_next = FLUSH;
            end
            FLUSH: begin
                pixel_out_valid = 1'b1;
                cnt_next        = cnt_inc;
                if (cnt_inc >= flush_total) begin
                    cnt_next   = '0;
                    state_next = F_RST;
                end
            end
            F_RST: begin
                conv_soft_rst = 1'b1;
                cnt_next      = cnt_inc;
                if (cnt_inc >= 32'(FLUSH_RST_CYCLES)) begin
                    cnt_next   = '0;
                    state_next = F_GAP;
                end
            end
            F_GAP: begin
                cnt_next = cnt_inc;
                if (cnt_inc >= 32'(FLUSH_GAP_CYCLES)) begin
                    cnt_next   = '0;
                    state_next = NEXT;
                end
            end
            NEXT: begin
                og_advance = 1'b1;
                if ({1'b0, og} + 9'd1 == {1'b0, co_q}) begin
                    state_next = DONE;
                end else begin
                    load_og    = 1'b1;
                    state_next = W_RST;
                end
            end
            DONE: begin
                layer_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            co_q              <= '0;
            ci_q              <= '0;
            w_q               <= '0;
            h_q               <= '0;
            cnt               <= '0;
            og                <= '0;
            done_seen         <= 1'b0;
            err_last          <= 1'b0;
            conv_output_group <= '0;
            conv_quant_m      <= '0;
            conv_quant_n      <= '0;
        end else begin
            cnt <= cnt_next;
            if (accept) begin
                co_q      <= cfg_co_groups;
                ci_q      <= cfg_ci_groups;
                w_q       <= cfg_img_width;
                h_q       <= cfg_img_height;
                og        <= '0;
                err_last  <= 1'b0;
                done_seen <= 1'b0;
            end
            if (og_advance) og <= og + 8'd1;
            // Registered table read. The values hold until the next OG.
            if (load_og) begin
                conv_output_group <= og_load;
                conv_quant_m      <= qt_m[qt_idx];
                conv_quant_n      <= qt_n[qt_idx];
            end
            // A done that arrives during the go cycle or the stream is not lost.
            if (state == GO)    done_seen <= conv_done;
            else if (conv_done) done_seen <= 1'b1;
            if (state == STREAM && px_s_valid && (px_s_last != pixel_out_last))
                err_last <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (qt_wr_en) begin
            qt_m[qt_wr_addr] <= qt_wr_m;
            qt_n[qt_wr_addr] <= qt_wr_n;
        end
    end

endmodule
